// File: rtl/button_event_decoder.sv
// button_event_decoder: classifies debounced pushbutton gestures as short,
// long or double presses, and emits one registered single-cycle pulse for
// each gesture.
module button_event_decoder #(
    parameter int LONG_CYC = 50_000_000,  // hold cycles that make a long press
    parameter int DBL_CYC  = 15_000_000,  // release-to-press window for a double
    parameter int CW       = 26           // counter width, 2^CW > both thresholds
) (
    input  logic clk,
    input  logic reset,
    input  logic db_level,
    input  logic db_tick,
    output logic short_tick,
    output logic long_tick,
    output logic double_tick,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESSED   = 3'd1,
        LONG_HELD = 3'd2,
        GAP       = 3'd3,
        SECOND    = 3'd4
    } state_t;

    // Terminal counts. The counter starts at 0 on the edge that enters the
    // state, so cnt == N-1 on the Nth edge after entry.
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] DBL_LAST  = CW'(DBL_CYC - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          short_q, short_d;
    logic          long_q, long_d;
    logic          double_q, double_d;
    logic          busy_q, busy_d;

    // Next-state, counter and event-pulse decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (db_tick) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end
            end
            PRESSED: begin
                if (!db_level) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG_HELD;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            LONG_HELD: begin
                // Waiting for release only; the gesture was already reported.
                if (!db_level) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                // A press on the final window cycle still counts as a double.
                if (db_tick) begin
                    state_d  = SECOND;
                    cnt_d    = '0;
                    double_d = 1'b1;
                end else if (cnt_q == DBL_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    short_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SECOND: begin
                // No long detection here; just wait for the second release.
                if (!db_level) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
            busy_q   <= busy_d;
        end
    end

    assign short_tick  = short_q;
    assign long_tick   = long_q;
    assign double_tick = double_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG_CYC=20, DBL_CYC=10.
module tb_button_event_decoder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic db_level = 1'b0;
    logic db_tick = 1'b0;
    logic short_tick, long_tick, double_tick, busy;

    button_event_decoder #(.LONG_CYC(20), .DBL_CYC(10), .CW(26)) dut (
        .clk(clk), .reset(reset), .db_level(db_level), .db_tick(db_tick),
        .short_tick(short_tick), .long_tick(long_tick),
        .double_tick(double_tick), .busy(busy)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Edge bookkeeping: ecnt numbers posedges; per-test pulse counts and
    // the edge of the first occurrence of each pulse.
    int ecnt = 0;
    int n_short, n_long, n_dbl, n_ovl;
    int e_short, e_long, e_dbl, e_bfall;
    logic prev_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        n_short = 0; n_long = 0; n_dbl = 0; n_ovl = 0;
        e_short = -1; e_long = -1; e_dbl = -1; e_bfall = -1;
    endtask

    // Drive one cycle of inputs, let the edge sample them, observe at +1.
    task automatic cyc(input logic lvl, input logic tk);
        db_level = lvl;
        db_tick  = tk;
        @(posedge clk);
        ecnt++;
        #1;
        if (short_tick)  begin n_short++; if (e_short < 0) e_short = ecnt; end
        if (long_tick)   begin n_long++;  if (e_long  < 0) e_long  = ecnt; end
        if (double_tick) begin n_dbl++;   if (e_dbl   < 0) e_dbl   = ecnt; end
        if ((32'(short_tick) + 32'(long_tick) + 32'(double_tick)) > 1) n_ovl++;
        if (prev_busy === 1'b1 && busy === 1'b0) e_bfall = ecnt;
        prev_busy = busy;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
    endtask

    int e0, r0;

    initial begin
        prev_busy = 1'b0;
        clr();

        // 1: reset with db_tick pulsing, then one quiet cycle
        reset = 1'b1;
        cyc(1'b0, 1'b1);
        chk("rst_out_c0", {short_tick, long_tick, double_tick, busy}, 0);
        cyc(1'b0, 1'b0);
        chk("rst_out_c1", {short_tick, long_tick, double_tick, busy}, 0);
        cyc(1'b0, 1'b1);
        chk("rst_out_c2", {short_tick, long_tick, double_tick, busy}, 0);
        reset = 1'b0;
        cyc(1'b0, 1'b0);
        chk("post_rst_idle", {short_tick, long_tick, double_tick, busy}, 0);

        // 2: short press
        clr();
        cyc(1'b0, 1'b1); e0 = ecnt;
        chk("short_busy_rise", busy, 1);
        hold(5);
        cyc(1'b0, 1'b0); r0 = ecnt;
        idle(12);
        chk("short_cnt", n_short, 1);
        chk("short_edge", e_short - r0, 10);
        chk("short_no_long_dbl", n_long + n_dbl, 0);
        chk("short_busy_fall", e_bfall - r0, 10);

        // 3: long press, held 30 cycles
        clr();
        cyc(1'b0, 1'b1); e0 = ecnt;
        hold(30);
        cyc(1'b0, 1'b0); r0 = ecnt;
        idle(15);
        chk("long_cnt", n_long, 1);
        chk("long_edge", e_long - e0, 20);
        chk("long_no_short_dbl", n_short + n_dbl, 0);
        chk("long_busy_fall", e_bfall - r0, 0);

        // 4: double press, second hold long enough to be long if it counted
        clr();
        cyc(1'b0, 1'b1);
        hold(4);
        cyc(1'b0, 1'b0); r0 = ecnt;
        idle(2);
        cyc(1'b0, 1'b1);
        hold(40);
        cyc(1'b0, 1'b0);
        chk("dbl_busy_fall", e_bfall, ecnt);
        idle(15);
        chk("dbl_cnt", n_dbl, 1);
        chk("dbl_edge", e_dbl - r0, 3);
        chk("dbl_no_short_long", n_short + n_long, 0);

        // 5a: tick sampled exactly at R0+10 is a double
        clr();
        cyc(1'b0, 1'b1);
        hold(3);
        cyc(1'b0, 1'b0); r0 = ecnt;
        idle(9);
        cyc(1'b0, 1'b1);
        hold(2);
        idle(13);
        chk("edge10_dbl_cnt", n_dbl, 1);
        chk("edge10_dbl_edge", e_dbl - r0, 10);
        chk("edge10_no_short", n_short, 0);

        // 5b: tick at R0+11 is too late: short at R0+10, then a new press
        clr();
        cyc(1'b0, 1'b1);
        hold(3);
        cyc(1'b0, 1'b0); r0 = ecnt;
        idle(10);
        cyc(1'b0, 1'b1);
        chk("edge11_new_press_busy", busy, 1);
        hold(2);
        idle(13);
        chk("edge11_short_edge", e_short - r0, 10);
        chk("edge11_short_cnt", n_short, 2);
        chk("edge11_no_dbl_long", n_dbl + n_long, 0);

        // 6: reset during a held press, then normal decoding
        clr();
        cyc(1'b0, 1'b1);
        hold(15);
        reset = 1'b1;
        hold(2);
        chk("midrst_busy", busy, 0);
        reset = 1'b0;
        hold(10);
        chk("midrst_idle_busy", busy, 0);
        idle(2);
        chk("midrst_no_event", n_short + n_long + n_dbl, 0);
        cyc(1'b0, 1'b1);
        hold(3);
        cyc(1'b0, 1'b0); r0 = ecnt;
        idle(12);
        chk("resume_short_edge", e_short - r0, 10);
        chk("resume_only_short", n_short * 100 + n_long * 10 + n_dbl, 100);

        chk("no_overlap", n_ovl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
